// File: rtl/spi_slave_cfg_burst.sv
// SPI slave front end for the RRAM configuration register file and FSM trigger.
// Frames carry a 2-bit opcode, then an optional address, then burst data words.
// Supported frames: register reads and writes with auto-increment, a status
// readback, and a go trigger that is dropped while the FSM is busy.
module spi_slave_cfg_burst #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int N_REGS = 20,
    parameter int DIAG_W = 16
) (
    input  logic                       sclk,
    input  logic                       rst_n,
    input  logic                       sc,
    input  logic                       mosi,
    output logic                       miso,
    output logic                       miso_oe_n,
    output logic [N_REGS*DATA_W-1:0]   cfg_o,
    output logic                       fsm_go,
    input  logic                       rram_busy,
    input  logic [DIAG_W-1:0]          diag_bits
);

    localparam int CNT_W = $clog2((DATA_W > ADDR_W) ? DATA_W : ADDR_W) + 1;

    typedef enum logic [2:0] {IDLE, OPC, ADDR, WDATA, RDATA, STAT, DONE} state_t;
    typedef enum logic [1:0] {OP_READ = 2'b00, OP_WRITE = 2'b01, OP_STAT = 2'b10, OP_GO = 2'b11} opcode_t;

    state_t              state, state_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic [ADDR_W-1:0]   addr, addr_nx;
    // miso holds the outgoing MSB; shreg holds the remaining bits of a read
    // word, or the bits of a write word received so far
    logic [DATA_W-2:0]   shreg, shreg_nx;
    logic                opc_hi, opc_hi_nx;
    logic                op_wr, op_wr_nx;
    logic                miso_nx, oe_n_nx, go_nx;
    logic                go_dropped, dropped_nx;
    logic                wr_en;
    logic [DATA_W-1:0]   wr_data;
    logic [DATA_W-1:0]   stat_word;
    logic [DATA_W-1:0]   regs [N_REGS];

    // Register i; out-of-range addresses read back as zero
    function automatic logic [DATA_W-1:0] read_word(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] w;
        w = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (a == ADDR_W'(i)) w = regs[i];
        end
        return w;
    endfunction

    // Address after a data word; wraps at N_REGS-1, and any out-of-range address goes to 0
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        if (a >= ADDR_W'(N_REGS - 1)) return '0;
        return a + ADDR_W'(1);
    endfunction

    assign stat_word = DATA_W'({go_dropped, rram_busy, diag_bits}) << (DATA_W - DIAG_W - 2);

    // Expose the register file as one flat vector
    for (genvar g = 0; g < N_REGS; g++) begin : g_cfg
        assign cfg_o[g*DATA_W +: DATA_W] = regs[g];
    end

    // Frame decoder: next state, shifter, counter and registered outputs
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        addr_nx    = addr;
        shreg_nx   = shreg;
        opc_hi_nx  = opc_hi;
        op_wr_nx   = op_wr;
        miso_nx    = 1'b0;
        oe_n_nx    = 1'b1;
        go_nx      = 1'b0;
        dropped_nx = go_dropped;
        wr_en      = 1'b0;
        wr_data    = {shreg, mosi};
        if (!sc) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    opc_hi_nx = mosi;
                    state_nx  = OPC;
                end
                OPC: begin
                    op_wr_nx = mosi;
                    cnt_nx   = '0;
                    case (opcode_t'({opc_hi, mosi}))
                        OP_READ, OP_WRITE: state_nx = ADDR;
                        OP_STAT: begin
                            {miso_nx, shreg_nx} = stat_word;
                            oe_n_nx    = 1'b0;
                            dropped_nx = 1'b0;
                            state_nx   = STAT;
                        end
                        OP_GO: begin
                            if (rram_busy) dropped_nx = 1'b1;
                            else           go_nx      = 1'b1;
                            state_nx = DONE;
                        end
                        default: state_nx = DONE;
                    endcase
                end
                ADDR: begin
                    addr_nx = {addr[ADDR_W-2:0], mosi};
                    if (cnt == CNT_W'(ADDR_W - 1)) begin
                        cnt_nx = '0;
                        if (op_wr) begin
                            state_nx = WDATA;
                        end else begin
                            {miso_nx, shreg_nx} = read_word(addr_nx);
                            oe_n_nx  = 1'b0;
                            state_nx = RDATA;
                        end
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                WDATA: begin
                    shreg_nx = wr_data[DATA_W-2:0];
                    if (cnt == CNT_W'(DATA_W - 1)) begin
                        wr_en   = 1'b1;
                        addr_nx = next_addr(addr);
                        cnt_nx  = '0;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                RDATA: begin
                    oe_n_nx = 1'b0;
                    if (cnt == CNT_W'(DATA_W - 1)) begin
                        addr_nx = next_addr(addr);
                        {miso_nx, shreg_nx} = read_word(addr_nx);
                        cnt_nx  = '0;
                    end else begin
                        {miso_nx, shreg_nx} = {shreg, 1'b0};
                        cnt_nx  = cnt + CNT_W'(1);
                    end
                end
                STAT: begin
                    oe_n_nx = 1'b0;
                    {miso_nx, shreg_nx} = {shreg, 1'b0};
                end
                DONE: state_nx = DONE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // State register and output flops
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            addr       <= '0;
            shreg      <= '0;
            opc_hi     <= 1'b0;
            op_wr      <= 1'b0;
            miso       <= 1'b0;
            miso_oe_n  <= 1'b1;
            fsm_go     <= 1'b0;
            go_dropped <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            addr       <= addr_nx;
            shreg      <= shreg_nx;
            opc_hi     <= opc_hi_nx;
            op_wr      <= op_wr_nx;
            miso       <= miso_nx;
            miso_oe_n  <= oe_n_nx;
            fsm_go     <= go_nx;
            go_dropped <= dropped_nx;
        end
    end

    // Configuration register file; writes beyond N_REGS match no entry and are ignored
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < N_REGS; i++) begin
                if (addr == ADDR_W'(i)) regs[i] <= wr_data;
            end
        end
    end

endmodule
